ad5543_frame_rx: RTL and testbench
==================================

# ad5543_frame_rx

Receive-side deserializer for the 16-bit AD5543 serial DAC link. It oversamples the three-wire interface (sclk, sdi, cs_n) in the aclk domain and rebuilds each MSB-first word. On every cs_n rising edge it either presents the word with a one-cycle valid strobe or flags a malformed frame. It sits in loopback and self-check paths: it monitors the DAC driver's pins and returns the words actually transmitted to the checker or capture logic.

## Interface
- DW, 16, bits per frame; also the width of data.
- SYNC_STAGES, 2, synchronizer depth on sclk/sdi/cs_n; legal range 2..4.
- aclk  input  1  system clock; all logic is on its rising edge.
- areset_n  input  1  asynchronous, active-low reset.
- en  input  1  enable; when low, the block is forced to IDLE and no strobes are issued.
- sclk  input  1  serial clock from the link, asynchronous to aclk.
- sdi  input  1  serial data, sampled on sclk rising edges, MSB first.
- cs_n  input  1  active-low frame select.
- data  output  DW  last good word; held until the next good frame.
- valid  output  1  one-cycle strobe; data updated this cycle.
- frame_err  output  1  one-cycle strobe; the frame ended with a bit count other than DW.
- busy  output  1  high while the state is ACTIVE.
- frame_cnt  output  16  count of good frames; wraps 0xFFFF -> 0.

## Operation
- sclk, sdi and cs_n each pass through an SYNC_STAGES-deep flop chain.
  - Reset values: sclk chain 0, sdi chain 0, cs_n chain 1.
  - All three chains have identical depth, so synchronized sdi stays aligned with synchronized sclk.
- One extra register per synchronized sclk and cs_n provides edge detection.
  - sclk_rise = sclk_s & ~sclk_q
  - cs_fall = ~cs_s & cs_q
  - cs_rise = cs_s & ~cs_q
- State machine, two states:
  - IDLE -> ACTIVE on cs_fall while en=1. Clear shift register and bit_cnt.
  - In ACTIVE, on sclk_rise: shift_reg <= {shift_reg[DW-2:0], sdi_s}; bit_cnt++.
  - bit_cnt is $clog2(DW)+2 bits wide and saturates at DW+1. Extra bits keep shifting, but the count stays marked as overrun.
  - ACTIVE -> IDLE on cs_rise.
    - If bit_cnt==DW: data <= shift_reg, valid=1, frame_cnt++.
    - Otherwise: frame_err=1; data and frame_cnt are unchanged.
  - en=0 in any state: go to IDLE next cycle. No valid or frame_err is issued, and a partial frame is discarded silently. The synchronizers keep running.
- Simultaneous events:
  - sclk_rise and cs_rise in the same cycle: the bit is shifted and counted first, then the frame is evaluated with the updated count.
  - sclk_rise and cs_fall in the same cycle: the edge is not sampled, since setup to cs_n is violated.
  - sclk_rise in IDLE: ignored.
  - cs_fall while ACTIVE cannot occur, because it requires a prior cs_rise.
- Reset, asynchronous at any time: all outputs return to their reset values immediately and state goes to IDLE. A frame in flight is lost with no strobe.

## Timing
- Reset values:
  - data=0, valid=0, frame_err=0, busy=0, frame_cnt=0.
  - state=IDLE, bit_cnt=0, shift_reg=0.
- Input constraints:
  - sclk high and low phases must each be at least 2 aclk periods, i.e. sclk <= aclk/4.
  - sdi must be stable for at least 2 aclk periods around each sclk rise.
  - cs_n high time between frames must be at least 2 aclk periods.
- Pin-to-action latency: an action happens on the (SYNC_STAGES+1)th aclk rising edge after the first edge that samples the new pin level. With SYNC_STAGES=2 this is the 3rd edge.
  - valid and frame_err rise on that edge after cs_n goes high.
  - busy rises on that edge after cs_n goes low.
- valid and frame_err are never high together, and never high for two consecutive cycles. The minimum spacing between strobes is set by the cs_n high time.

## Test plan
- Reset, then one frame of 0xA5C3: 16 sclk pulses at aclk/8, MSB first, framed by cs_n.
  -> valid for exactly one cycle on the 3rd aclk edge after cs_n rises; data=0xA5C3; frame_cnt=1; frame_err stays 0.
- Frames 0xFFFF, 0x0000 and 0x8001 back to back, with 2 aclk of cs_n high between them.
  -> three valid pulses carrying those words in order; frame_cnt=3.
- Short frame (15 sclk) and long frame (17 sclk).
  -> frame_err pulse for each; no valid; data keeps the previous good word; frame_cnt unchanged.
- Last sclk rise arranged so the synchronized sclk rise and cs_n rise coincide, word 0x1234.
  -> bit counted, valid=1, data=0x1234.
- areset_n pulsed low after 8 bits of a frame.
  -> all outputs go to 0 asynchronously. The trailing bits and cs_n rise produce no strobe. The next full frame of 0x5A5A gives valid with data=0x5A5A.
- en dropped mid-frame, then raised before the next frame.
  -> no strobes for the interrupted frame; the next frame of 0x00FF is received normally.
- Loopback: AD5543 DAC driver pins drive this block, DAC driver clocked at aclk/4 of this block, data inputs swept 0x0000..0xFFFF in steps of 0x1111.
  -> every received word equals the transmitted word; frame_err never asserts.

Source files
------------

// File: rtl/ad5543_frame_rx.sv
// ad5543_frame_rx: oversampling receiver for the 16-bit AD5543 three-wire link.
// sclk/sdi/cs_n are synchronized into aclk and each MSB-first word is rebuilt.
// On cs_n rising the word is either presented with a one-cycle valid strobe or
// reported as malformed with a one-cycle frame_err strobe.
// SYNC_STAGES must lie in 2..4.
module ad5543_frame_rx #(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          aclk,
  input  logic          areset_n,
  input  logic          en,
  input  logic          sclk,
  input  logic          sdi,
  input  logic          cs_n,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          frame_err,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  localparam int CW = $clog2(DW) + 2;
  localparam logic [CW-1:0] CNT_FULL = CW'(DW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_q_r;
  logic                   cs_q_r;
  logic [SYNC_STAGES:0]   prime_r;

  state_t                 state_r;
  logic [DW-1:0]          shift_reg_r;
  logic [CW-1:0]          bit_cnt_r;
  logic [DW-1:0]          data_r;
  logic                   valid_r;
  logic                   frame_err_r;
  logic                   busy_r;
  logic [15:0]            frame_cnt_r;

  logic                   sclk_s;
  logic                   sdi_s;
  logic                   cs_s;
  logic                   edge_ok_s;
  logic                   sclk_rise_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic [DW-1:0]          shift_next_s;
  logic [CW-1:0]          cnt_next_s;

  // Pin synchronizers plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      sdi_sync_r  <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_q_r    <= 1'b0;
      cs_q_r      <= 1'b1;
      prime_r     <= {(SYNC_STAGES + 1){1'b0}};
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      sdi_sync_r  <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_q_r    <= sclk_sync_r[SYNC_STAGES-1];
      cs_q_r      <= cs_sync_r[SYNC_STAGES-1];
      prime_r     <= {prime_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];

  // Edges are only trusted once both the synchronized level and its delayed
  // copy hold real pin samples; otherwise a cs_n held low across reset would
  // look like a fresh frame start against the reset value of the chain.
  assign edge_ok_s   = prime_r[SYNC_STAGES];
  assign sclk_rise_s = edge_ok_s & sclk_s & ~sclk_q_r;
  assign cs_fall_s   = edge_ok_s & ~cs_s & cs_q_r;
  assign cs_rise_s   = edge_ok_s & cs_s & ~cs_q_r;

  // Next shift/count values; a coincident cs rise sees the updated count.
  always_comb begin
    shift_next_s = shift_reg_r;
    cnt_next_s   = bit_cnt_r;
    if (sclk_rise_s) begin
      shift_next_s = {shift_reg_r[DW-2:0], sdi_s};
      if (bit_cnt_r < CNT_SAT) begin
        cnt_next_s = bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_next_s = bit_cnt_r;
      end
    end else begin
      shift_next_s = shift_reg_r;
      cnt_next_s   = bit_cnt_r;
    end
  end

  // Frame state machine with registered strobes, word and counters.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r     <= IDLE;
      shift_reg_r <= {DW{1'b0}};
      bit_cnt_r   <= {CW{1'b0}};
      data_r      <= {DW{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      if (!en) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (cs_fall_s) begin
              state_r     <= ACTIVE;
              busy_r      <= 1'b1;
              shift_reg_r <= {DW{1'b0}};
              bit_cnt_r   <= {CW{1'b0}};
            end else begin
              busy_r <= 1'b0;
            end
          end
          ACTIVE: begin
            shift_reg_r <= shift_next_s;
            bit_cnt_r   <= cnt_next_s;
            if (cs_rise_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              if (cnt_next_s == CNT_FULL) begin
                data_r      <= shift_next_s;
                valid_r     <= 1'b1;
                frame_cnt_r <= frame_cnt_r + 16'd1;
              end else begin
                frame_err_r <= 1'b1;
              end
            end else begin
              busy_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_ad5543_frame_rx.sv
// Bench for ad5543_frame_rx: directed and randomized frames, a word-level
// reference model (a frame is good exactly when it carries 16 bits) and a
// monitor that collects every strobe the receiver issues.
module tb_ad5543_frame_rx;

  logic        aclk;
  logic        areset_n;
  logic        en;
  logic        sclk;
  logic        sdi;
  logic        cs_n;
  logic [15:0] data;
  logic        valid;
  logic        frame_err;
  logic        busy;
  logic [15:0] frame_cnt;

  ad5543_frame_rx #(.DW(16), .SYNC_STAGES(2)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .en        (en),
    .sclk      (sclk),
    .sdi       (sdi),
    .cs_n      (cs_n),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [15:0] exp_q[$];
  int          exp_err = 0;
  logic [15:0] exp_data = 16'h0000;
  logic [15:0] exp_cnt  = 16'h0000;

  // monitor state
  logic [15:0] got_q[$];
  int          got_err = 0;
  int          both_hi = 0;
  int          consec  = 0;
  bit          prev_strobe = 1'b0;

  // collect strobes just after every active edge
  always begin
    @(posedge aclk);
    #1;
    if (valid) got_q.push_back(data);
    if (frame_err) got_err++;
    if (valid && frame_err) both_hi++;
    if ((valid || frame_err) && prev_strobe) consec++;
    prev_strobe = valid || frame_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_frame(input logic [31:0] word, input int nbits);
    if (nbits == 16) begin
      exp_q.push_back(word[15:0]);
      exp_data = word[15:0];
      exp_cnt  = exp_cnt + 16'd1;
    end else begin
      exp_err++;
    end
  endtask

  task automatic cs_low();
    repeat (2) @(negedge aclk);
    sclk = 1'b0;
    cs_n = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      sdi = word[nbits-1-i];
      repeat (half) @(negedge aclk);
      sclk = 1'b1;
      repeat (half) @(negedge aclk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (2) @(negedge aclk);
    cs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int half);
    cs_low();
    send_bits(word, nbits, half);
    cs_high();
    model_frame(word, nbits);
  endtask

  task automatic check_phase(input string tag);
    repeat (8) @(negedge aclk);
    chk({tag, "_nvalid"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) chk({tag, "_word"}, {16'h0, got_q[i]}, {16'h0, exp_q[i]});
    end
    chk({tag, "_nerr"}, got_err, exp_err);
    chk({tag, "_data"}, {16'h0, data}, {16'h0, exp_data});
    chk({tag, "_cnt"}, {16'h0, frame_cnt}, {16'h0, exp_cnt});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    int          nb;
    int          hf;
    int          sel;

    areset_n = 1'b0;
    en       = 1'b1;
    sclk     = 1'b0;
    sdi      = 1'b0;
    cs_n     = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_data", {16'h0, data}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cnt", {16'h0, frame_cnt}, 32'h0);
    areset_n = 1'b1;
    repeat (4) @(negedge aclk);

    // first frame with exact strobe timing
    cs_low();
    send_bits(32'hA5C3, 16, 4);
    chk("f1_busy", {31'h0, busy}, 32'h1);
    cs_high();
    model_frame(32'hA5C3, 16);
    @(posedge aclk); #1;
    chk("f1_lat_e1", {31'h0, valid}, 32'h0);
    @(posedge aclk); #1;
    chk("f1_lat_e2", {31'h0, valid}, 32'h0);
    @(posedge aclk); #1;
    chk("f1_lat_e3", {31'h0, valid}, 32'h1);
    chk("f1_lat_data", {16'h0, data}, 32'hA5C3);
    @(posedge aclk); #1;
    chk("f1_lat_e4", {31'h0, valid}, 32'h0);
    check_phase("f1");

    // back to back frames, minimum cs_n high time
    send_frame(32'hFFFF, 16, 4);
    send_frame(32'h0000, 16, 4);
    send_frame(32'h8001, 16, 4);
    check_phase("b2b");

    // short and long frames
    send_frame(32'h00007FFF, 15, 4);
    send_frame(32'h0001ABCD, 17, 4);
    check_phase("short_long");

    // last sclk rise coincident with cs_n rise
    cs_low();
    send_bits(32'h1234 >> 1, 15, 4);
    sdi = 1'b0;
    repeat (4) @(negedge aclk);
    sclk = 1'b1;
    cs_n = 1'b1;
    repeat (4) @(negedge aclk);
    sclk = 1'b0;
    model_frame(32'h1234, 16);
    check_phase("coincide");

    // asynchronous reset in the middle of a frame
    cs_low();
    send_bits(32'hC3, 8, 4);
    chk("rst_mid_busy_before", {31'h0, busy}, 32'h1);
    #3;
    areset_n = 1'b0;
    #1;
    chk("rst_mid_data", {16'h0, data}, 32'h0);
    chk("rst_mid_cnt", {16'h0, frame_cnt}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_valid", {31'h0, valid}, 32'h0);
    chk("rst_mid_err", {31'h0, frame_err}, 32'h0);
    exp_data = 16'h0000;
    exp_cnt  = 16'h0000;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    send_bits(32'h3C, 8, 4);
    cs_high();
    check_phase("rst_tail");
    send_frame(32'h5A5A, 16, 4);
    check_phase("rst_next");

    // enable dropped mid-frame
    cs_low();
    send_bits(32'h3C, 8, 4);
    @(negedge aclk);
    en = 1'b0;
    send_bits(32'h3C, 8, 4);
    cs_high();
    repeat (4) @(negedge aclk);
    chk("en_busy", {31'h0, busy}, 32'h0);
    check_phase("en_drop");
    en = 1'b1;
    send_frame(32'h00FF, 16, 4);
    check_phase("en_next");

    // randomized frames: random word, bit count and sclk rate
    for (int k = 0; k < 12; k++) begin
      w   = $urandom;
      sel = $urandom_range(0, 3);
      nb  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      hf  = $urandom_range(2, 5);
      send_frame(w, nb, hf);
    end
    check_phase("rand");

    // loopback sweep at the fastest legal sclk
    for (int k = 0; k < 16; k++) begin
      send_frame(32'(k) * 32'h1111, 16, 2);
    end
    check_phase("loop");

    chk("strobe_overlap", both_hi, 0);
    chk("strobe_consec", consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
